// File: rtl/cmplx_dot_seq.sv
// cmplx_dot_seq: switch-stepped complex dot product, sum of (a_re + j*a_im) * (q_re + j*q_im), shown on LED.
//   Ports:
//     clk        rising-edge clock
//     reset_n    asynchronous active-low reset
//     handshake  asynchronous advance strobe (synchronised internally)
//     data_in    W-bit signed operand word
//     LED        displayed result word (0 outside SHOW_RE/SHOW_IM)
//     res_valid  high while a result is displayed
//     ovf        displayed result saturated
//   Optional macro CMPLX_ROUND_EN: round half up before the FRAC shift instead of truncating.
module cmplx_dot_seq #(
  parameter int W       = 8,
  parameter int FRAC    = 0,
  parameter int N_TERMS = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         handshake,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] LED,
  output logic         res_valid,
  output logic         ovf
);
  localparam int IW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int AW = 2 * W + 1 + $clog2(N_TERMS);
  localparam logic [IW-1:0] LAST = IW'(N_TERMS - 1);
`ifdef CMPLX_ROUND_EN
  localparam logic signed [AW:0] RND = (FRAC > 0) ? (AW + 1)'(1) << ((FRAC > 0) ? FRAC - 1 : 0) : '0;
`else
  localparam logic signed [AW:0] RND = '0;
`endif
  localparam logic signed [AW:0] SMAX = {{(AW - W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {LD_ARE, LD_AIM, LD_QRE, LD_QIM, CALC, SHOW_RE, SHOW_IM} state_t;
  state_t r_state, w_state_nx;
  logic [2:0] r_sync;
  logic signed [W-1:0] r_are, r_aim, r_qre, r_qim;
  logic signed [AW-1:0] r_acc_re, r_acc_im, w_acc_re_nx, w_acc_im_nx, w_t_re, w_t_im;
  logic [IW-1:0] r_idx;
  logic [W-1:0] r_led;
  logic r_vld, r_ovf, w_ev, w_clr;
  logic [W:0] w_sr, w_si;
  function automatic logic signed [AW-1:0] mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    return $signed({{(AW - 2 * W){p[2*W-1]}}, p});
  endfunction
  // {ovf, value}: optional rounding, arithmetic shift, then clamp to W bits
  function automatic logic [W:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW:0] s;
    s = ($signed({a[AW-1], a}) + RND) >>> FRAC;
    return (s > SMAX) ? {1'b1, SMAX[W-1:0]} : (s < SMIN) ? {1'b1, SMIN[W-1:0]} : {1'b0, s[W-1:0]};
  endfunction
  // r_sync[1] is the synchronised strobe, r_sync[2] its previous value
  assign w_ev = r_sync[1] & ~r_sync[2];
  assign w_clr = (r_state == SHOW_IM) && w_ev;
  assign w_t_re = mul(r_are, r_qre) - mul(r_aim, r_qim);
  assign w_t_im = mul(r_are, r_qim) + mul(r_aim, r_qre);
  assign w_acc_re_nx = w_clr ? '0 : (r_state == CALC) ? r_acc_re + w_t_re : r_acc_re;
  assign w_acc_im_nx = w_clr ? '0 : (r_state == CALC) ? r_acc_im + w_t_im : r_acc_im;
  // outputs are registered from the next state and next accumulator values
  assign w_sr = sat(w_acc_re_nx);
  assign w_si = sat(w_acc_im_nx);
  assign LED = r_led;
  assign res_valid = r_vld;
  assign ovf = r_ovf;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      LD_ARE:  w_state_nx = w_ev ? LD_AIM : LD_ARE;
      LD_AIM:  w_state_nx = w_ev ? LD_QRE : LD_AIM;
      LD_QRE:  w_state_nx = w_ev ? LD_QIM : LD_QRE;
      LD_QIM:  w_state_nx = w_ev ? CALC : LD_QIM;
      CALC:    w_state_nx = (r_idx == LAST) ? SHOW_RE : LD_ARE;
      SHOW_RE: w_state_nx = w_ev ? SHOW_IM : SHOW_RE;
      SHOW_IM: w_state_nx = w_ev ? LD_ARE : SHOW_IM;
      default: w_state_nx = LD_ARE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '0;
      r_state  <= LD_ARE;
      r_are    <= '0;
      r_aim    <= '0;
      r_qre    <= '0;
      r_qim    <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_idx    <= '0;
      r_led    <= '0;
      r_vld    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[1:0], handshake};
      r_state  <= w_state_nx;
      r_acc_re <= w_acc_re_nx;
      r_acc_im <= w_acc_im_nx;
      r_idx    <= w_clr ? '0 : (r_state == CALC && r_idx != LAST) ? r_idx + IW'(1) : r_idx;
      r_vld    <= (w_state_nx == SHOW_RE) || (w_state_nx == SHOW_IM);
      r_led    <= (w_state_nx == SHOW_RE) ? w_sr[W-1:0] : (w_state_nx == SHOW_IM) ? w_si[W-1:0] : '0;
      r_ovf    <= (w_state_nx == SHOW_RE) ? w_sr[W] : (w_state_nx == SHOW_IM) ? w_si[W] : 1'b0;
      if (w_ev && r_state == LD_ARE) r_are <= data_in;
      if (w_ev && r_state == LD_AIM) r_aim <= data_in;
      if (w_ev && r_state == LD_QRE) r_qre <= data_in;
      if (w_ev && r_state == LD_QIM) r_qim <= data_in;
    end
  end
endmodule

// File: tb/tb_cmplx_dot_seq.sv
// tb_cmplx_dot_seq: scoreboard bench for cmplx_dot_seq (three instances: default, N_TERMS=2, FRAC=4).
module tb_cmplx_dot_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic hs[3];
  logic [7:0] din[3];
  logic [7:0] led[3];
  logic rv[3];
  logic ov[3];
  typedef struct {
    int re;
    int im;
    bit ore;
    bit oim;
  } exp_t;
  exp_t sb[3][$];
  exp_t cur[3];
  logic [7:0] wq[$];
  logic [7:0] ll[3];
  bit lo[3];
  bit prv[3];
  int fr[3] = '{0, 0, 4};
  int errors = 0;
  int checks = 0;
`ifdef CMPLX_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  cmplx_dot_seq u0 (.clk(clk), .reset_n(reset_n), .handshake(hs[0]), .data_in(din[0]),
                    .LED(led[0]), .res_valid(rv[0]), .ovf(ov[0]));
  cmplx_dot_seq #(.N_TERMS(2)) u1 (.clk(clk), .reset_n(reset_n), .handshake(hs[1]), .data_in(din[1]),
                                   .LED(led[1]), .res_valid(rv[1]), .ovf(ov[1]));
  cmplx_dot_seq #(.FRAC(4)) u2 (.clk(clk), .reset_n(reset_n), .handshake(hs[2]), .data_in(din[2]),
                                .LED(led[2]), .res_valid(rv[2]), .ovf(ov[2]));

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int satv(longint v);
    return (v > 127) ? 127 : (v < -128) ? -128 : int'(v);
  endfunction

  task automatic send(int k, logic [7:0] v, int h);
    @(posedge clk);
    #2;
    din[k] = v;
    hs[k] = 1'b1;
    repeat (h) @(posedge clk);
    #2;
    hs[k] = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Push the mathematically expected display pair, then play the words and two advance events.
  task automatic txn(int k, int hold0);
    longint sr, si, ar, ai, qr, qi;
    exp_t e;
    sr = 0;
    si = 0;
    for (int t = 0; t < wq.size() / 4; t++) begin
      ar = $signed(wq[4*t]);
      ai = $signed(wq[4*t+1]);
      qr = $signed(wq[4*t+2]);
      qi = $signed(wq[4*t+3]);
      sr += ar * qr - ai * qi;
      si += ar * qi + ai * qr;
    end
    if (RND_EN && fr[k] > 0) begin
      sr += longint'(1) << (fr[k] - 1);
      si += longint'(1) << (fr[k] - 1);
    end
    sr = sr >>> fr[k];
    si = si >>> fr[k];
    e.re = satv(sr);
    e.im = satv(si);
    e.ore = (sr > 127) || (sr < -128);
    e.oim = (si > 127) || (si < -128);
    sb[k].push_back(e);
    for (int i = 0; i < wq.size(); i++) begin
      send(k, wq[i], (i == 0) ? hold0 : 5);
      if (i == 0 && hold0 > 5) begin
        @(posedge clk);
        #2 hs[k] = 1'b1;
        #3 hs[k] = 1'b0;
        repeat (4) @(posedge clk);
      end
    end
    send(k, 8'h00, 5);
    send(k, 8'h00, 5);
    wq.delete();
  endtask

  // Monitor: SHOW_RE word on res_valid rise, SHOW_IM word is the last one before res_valid falls.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rv[k] && !prv[k]) begin
          if (sb[k].size() == 0) begin
            chk($sformatf("u%0d_unexpected_result", k), 1, 0);
            cur[k] = '{re: 999, im: 999, ore: 1'b0, oim: 1'b0};
          end else begin
            cur[k] = sb[k].pop_front();
            chk($sformatf("u%0d_re_led", k), int'($signed(led[k])), cur[k].re);
            chk($sformatf("u%0d_re_ovf", k), int'(ov[k]), int'(cur[k].ore));
          end
        end
        if (rv[k]) begin
          ll[k] = led[k];
          lo[k] = ov[k];
        end
        if (!rv[k] && prv[k]) begin
          chk($sformatf("u%0d_im_led", k), int'($signed(ll[k])), cur[k].im);
          chk($sformatf("u%0d_im_ovf", k), int'(lo[k]), int'(cur[k].oim));
          chk($sformatf("u%0d_idle_led", k), int'(led[k]), 0);
          chk($sformatf("u%0d_idle_ovf", k), int'(ov[k]), 0);
        end
        prv[k] = rv[k];
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hs[k] = 1'b0;
      din[k] = '0;
      prv[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_reset_led", k), int'(led[k]), 0);
      chk($sformatf("u%0d_reset_valid", k), int'(rv[k]), 0);
      chk($sformatf("u%0d_reset_ovf", k), int'(ov[k]), 0);
    end
    #3 reset_n = 1'b1;
    wq = '{8'd3, 8'd2, 8'd1, 8'd4};
    txn(0, 5);
    wq = '{8'd100, 8'd0, 8'd100, 8'd0};
    txn(0, 5);
    send(0, 8'd3, 5);
    send(0, 8'd2, 5);
    send(0, 8'd1, 5);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_reset_led", int'(led[0]), 0);
    chk("mid_reset_valid", int'(rv[0]), 0);
    chk("mid_reset_ovf", int'(ov[0]), 0);
    #10 reset_n = 1'b1;
    wq = '{8'd3, 8'd2, 8'd1, 8'd4};
    txn(0, 5);
    wq = '{8'd3, 8'd2, 8'd1, 8'd4};
    txn(0, 50);
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) wq.push_back(8'($urandom_range(0, 255)));
      txn(0, 5);
    end
    wq = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 8'd3, 8'd0};
    txn(1, 5);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) wq.push_back(8'($urandom_range(0, 255)));
      txn(1, 5);
    end
    wq = '{8'd3, 8'd0, 8'd3, 8'd0};
    txn(2, 5);
    wq = '{8'hFD, 8'd0, 8'd3, 8'd0};
    txn(2, 5);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) wq.push_back(8'($urandom_range(0, 255)));
      txn(2, 5);
    end
    repeat (20) @(posedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("u%0d_results_pending", k), sb[k].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
